exp_sum_accum: RTL and testbench
================================

// Module: exp_sum_accum
// PURPOSE
//  Downstream neighbour of the RU stage in the Q6.10 softmax datapath. During the first
//  softmax pass it consumes the RU pow2 results 2^((x_i-max)*log2e), one per valid beat.
//  It accumulates exactly LEN of them into a wide accumulator and then emits one
//  saturated Q6.10 sum. That sum is fed back to RU in_0, where RU takes its log2 for the
//  second (normalisation) pass.
// PARAMETERS
//  DATA_W  16  sample/sum width, signed Q6.10 two's complement
//  FRAC_W  10  fractional bits (sum keeps the same binary point as the samples)
//  ACC_W   26  accumulator width; must be >= DATA_W + LEN_W
//  LEN_W   10  width of vector-length input (max vector 2^LEN_W - 1)
// PORTS
//  clk        in   1       rising-edge clock
//  rst        in   1       asynchronous reset, ACTIVE-LOW (0 = reset)
//  en         in   1       clock enable; en=0 freezes every register incl. outputs
//  start      in   1       begin new vector (sampled only in IDLE)
//  len        in   LEN_W   number of samples in the vector, latched on accepted start
//  valid_in   in   1       in_x carries a sample this cycle
//  in_x       in   DATA_W  RU out_1 (pow2 result), Q6.10
//  busy       out  1       high whenever state != IDLE
//  sum_valid  out  1       one-enabled-cycle pulse: sum_out/sum_ovf valid
//  sum_out    out  DATA_W  saturated Q6.10 sum of the LEN samples
//  sum_ovf    out  1       accumulator exceeded 16'h7FFF (sum_out clamped)
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, acc=0, cnt=0, len_q=0, busy=0, sum_valid=0,
//   sum_out=0, sum_ovf=0. Reset mid-vector aborts it; no partial sum is ever emitted.
//  All transitions below occur only on clk edges with en=1.
//  FSM states: IDLE, ACCUM, DONE.
//  IDLE:
//   - start=1 & len!=0: len_q<=len, acc<=0, cnt<=0, ->ACCUM.
//   - start=1 & len==0: start ignored, stay IDLE, no output.
//   - valid_in in IDLE is dropped (not accumulated).
//  ACCUM:
//   - On valid_in=1: acc<=acc+in_x, cnt<=cnt+1.
//   - in_x is a negative sample, or can only become negative through pow2 underflow.
//     In either case it is treated as 0 (msb set -> add 0). cnt still increments.
//   - When the accepted beat has cnt==len_q-1 (last sample): ->DONE on that same edge;
//     acc includes that sample.
//   - start is ignored in ACCUM and DONE (no restart, no len reload).
//  DONE (exactly one enabled cycle):
//   - sum_out<=(acc>16'h7FFF)?16'h7FFF:acc[15:0]; sum_ovf<=(acc>16'h7FFF);
//     sum_valid<=1; ->IDLE.
//   - valid_in during DONE is dropped.
//  Latency: last sample accepted at edge k -> sum_valid=1 after edge k+1, cleared after
//   the next enabled edge.
//  sum_out/sum_ovf hold their value until the next DONE or reset. sum_valid is a pulse.
//  Back-to-back: start may be asserted in the cycle sum_valid is high (state already
//   IDLE). The next vector is accepted on that edge.
//  en=0 in any state: no state, counter, accumulator or output change. A sum_valid that
//   is high stays high until the next enabled edge.
//  Accumulator cannot wrap: ACC_W >= DATA_W+LEN_W guarantees headroom for LEN_W-max
//   samples of 16'h7FFF.
// TESTING
//  1. start, len=4; in_x=0x0400 x4 (1.0 each) -> sum_valid 1 cycle after 4th beat,
//     sum_out=0x1000, sum_ovf=0.
//  2. len=3, samples spaced with valid_in gaps and en=0 stalls -> same sum as the
//     dense case; sum_valid stretched only across en=0 cycles.
//  3. len=40; in_x=0x7C00 x40 -> sum_out=0x7FFF, sum_ovf=1; busy low afterwards.
//  4. in_x=0x8400 (negative) inside a len=2 vector with 0x0200 -> sum_out=0x0200;
//     start with len=0 -> busy stays 0, no sum_valid.
//  5. rst pulled low mid-ACCUM (2 of 5 samples in) -> all outputs 0 immediately, no
//     sum_valid. A following len=1 vector with in_x=0x0100 gives 0x0100.
//  6. Back-to-back: restart on the sum_valid cycle -> second vector accumulates from 0,
//     and valid_in seen in IDLE/DONE is ignored.

Source files
------------

// File: rtl/exp_sum_accum.sv
// exp_sum_accum: sums LEN pow2 results from the RU stage into a wide accumulator and
// emits one saturated Q6.10 sum per vector, which feeds back into RU for the
// normalisation pass.
module exp_sum_accum #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned FRAC_W = 10,
  parameter int unsigned ACC_W  = 26,
  parameter int unsigned LEN_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic              valid_in,
  input  logic [DATA_W-1:0] in_x,
  output logic              busy,
  output logic              sum_valid,
  output logic [DATA_W-1:0] sum_out,
  output logic              sum_ovf
);

  // Largest positive DATA_W two's-complement value, used as the clamp level.
  localparam logic [DATA_W-1:0] SAT_MAX = {1'b0, {(DATA_W-1){1'b1}}};

  // Parameter sanity: headroom for a full-length vector and a sane binary point.
  if (ACC_W < DATA_W + LEN_W) begin : g_acc_w_check
    $error("exp_sum_accum: ACC_W must be >= DATA_W + LEN_W");
  end
  if (FRAC_W >= DATA_W) begin : g_frac_w_check
    $error("exp_sum_accum: FRAC_W must be < DATA_W");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t             state;
  logic [ACC_W-1:0]   acc;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   len_q;

  logic [ACC_W-1:0]   sample_c;
  logic               acc_ovf_c;
  logic               last_c;

  // Negative samples (pow2 underflow) contribute nothing; positives zero-extend.
  assign sample_c  = in_x[DATA_W-1] ? '0 : ACC_W'(in_x);

  // acc is never negative, so any set bit at or above the sign position means > SAT_MAX.
  assign acc_ovf_c = |acc[ACC_W-1:DATA_W-1];

  // Current accepted beat is the final sample of the vector.
  assign last_c    = (cnt == len_q - LEN_W'(1));

  // Control FSM, accumulator and registered outputs; en=0 freezes everything.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      len_q     <= '0;
      busy      <= 1'b0;
      sum_valid <= 1'b0;
      sum_out   <= '0;
      sum_ovf   <= 1'b0;
    end else if (en) begin
      sum_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (start && (len != '0)) begin
            len_q <= len;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (valid_in) begin
            acc <= acc + sample_c;
            cnt <= cnt + LEN_W'(1);
            if (last_c) begin
              state <= DONE;
            end
          end
        end
        DONE: begin
          sum_out   <= acc_ovf_c ? SAT_MAX : acc[DATA_W-1:0];
          sum_ovf   <= acc_ovf_c;
          sum_valid <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_exp_sum_accum.sv
// Self-checking bench for exp_sum_accum: randomized vectors checked against a
// plain-arithmetic reference sum with saturation.
module tb_exp_sum_accum;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        start;
  logic [9:0]  len;
  logic        valid_in;
  logic [15:0] in_x;
  logic        busy;
  logic        sum_valid;
  logic [15:0] sum_out;
  logic        sum_ovf;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  exp_sum_accum dut (
    .clk       (clk),
    .rst       (rst),
    .en        (en),
    .start     (start),
    .len       (len),
    .valid_in  (valid_in),
    .in_x      (in_x),
    .busy      (busy),
    .sum_valid (sum_valid),
    .sum_out   (sum_out),
    .sum_ovf   (sum_ovf)
  );

  // Reference: sum of non-negative samples, clamped to the Q6.10 maximum.
  function automatic void ref_sum(input logic [15:0] q[$], output logic [15:0] s,
                                  output logic o);
    int total = 0;
    foreach (q[i]) if (q[i][15] == 1'b0) total += int'(q[i]);
    o = (total > 32767);
    s = o ? 16'h7FFF : 16'(total);
  endfunction

  // All drive tasks start right after a falling edge and end right after one.
  task automatic begin_vec(input int n);
    en = 1'b1; start = 1'b1; len = 10'(n); valid_in = 1'b0;
    @(negedge clk);
    start = 1'b0; len = 10'(($urandom % 7) + 1);
  endtask

  // Feed samples with optional valid_in gaps and en=0 stalls; the final beat is
  // accepted on the rising edge just before return.
  task automatic feed(input logic [15:0] q[$], input int gap_pct, input int stall_pct);
    foreach (q[i]) begin
      while (int'($urandom % 100) < gap_pct) begin
        en = 1'b1; valid_in = 1'b0; in_x = 16'($urandom);
        @(negedge clk);
      end
      while (int'($urandom % 100) < stall_pct) begin
        en = 1'b0; valid_in = 1'($urandom); in_x = 16'($urandom);
        @(negedge clk);
      end
      en = 1'b1; valid_in = 1'b1; in_x = q[i];
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_checks++;
    if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL reset_sum_valid got=%b exp=0", sum_valid); end
    n_checks++;
    if (sum_out !== 16'h0) begin n_fail++; $display("FAIL reset_sum_out got=%h exp=0000", sum_out); end
    n_checks++;
    if (sum_ovf !== 1'b0) begin n_fail++; $display("FAIL reset_sum_ovf got=%b exp=0", sum_ovf); end
    n_checks++;
  endtask

  task automatic test_dense();
    logic [15:0] q[$] = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    begin_vec(4);
    if (busy !== 1'b1) begin n_fail++; $display("FAIL dense_busy got=%b exp=1", busy); end
    n_checks++;
    feed(q, 0, 0);
    valid_in = 1'b0;
    if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL dense_early_valid got=%b exp=0", sum_valid); end
    n_checks++;
    @(negedge clk);
    if (sum_valid !== 1'b1) begin n_fail++; $display("FAIL dense_latency got=%b exp=1", sum_valid); end
    n_checks++;
    if (sum_out !== 16'h1000 || sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL dense_sum got=%h/%b exp=1000/0", sum_out, sum_ovf);
    end
    n_checks++;
    @(negedge clk);
    if (sum_valid !== 1'b0 || busy !== 1'b0) begin
      n_fail++; $display("FAIL dense_pulse valid=%b busy=%b exp=0/0", sum_valid, busy);
    end
    n_checks++;
  endtask

  task automatic test_gaps_stalls();
    logic [15:0] q[$];
    logic [15:0] es;
    logic        eo;
    for (int i = 0; i < 3; i++) q.push_back(16'($urandom_range(0, 16'h1FFF)));
    ref_sum(q, es, eo);
    begin_vec(3);
    feed(q, 40, 40);
    valid_in = 1'b0;
    @(negedge clk);
    if (sum_valid !== 1'b1 || sum_out !== es || sum_ovf !== eo) begin
      n_fail++; $display("FAIL gaps_sum valid=%b got=%h/%b exp=%h/%b", sum_valid, sum_out, sum_ovf, es, eo);
    end
    n_checks++;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (sum_valid !== 1'b1 || sum_out !== es) begin
        n_fail++; $display("FAIL gaps_stretch cyc=%0d valid=%b got=%h exp=1/%h", c, sum_valid, sum_out, es);
      end
      n_checks++;
    end
    en = 1'b1;
    @(negedge clk);
    if (sum_valid !== 1'b0) begin n_fail++; $display("FAIL gaps_pulse_end got=%b exp=0", sum_valid); end
    n_checks++;
  endtask

  task automatic test_saturate();
    logic [15:0] q[$];
    for (int i = 0; i < 40; i++) q.push_back(16'h7C00);
    begin_vec(40);
    feed(q, 10, 0);
    valid_in = 1'b0;
    @(negedge clk);
    if (sum_valid !== 1'b1 || sum_out !== 16'h7FFF || sum_ovf !== 1'b1) begin
      n_fail++; $display("FAIL sat_sum valid=%b got=%h/%b exp=1/7fff/1", sum_valid, sum_out, sum_ovf);
    end
    n_checks++;
    @(negedge clk);
    if (busy !== 1'b0) begin n_fail++; $display("FAIL sat_busy got=%b exp=0", busy); end
    n_checks++;
  endtask

  task automatic test_negative_and_zero_len();
    logic [15:0] q[$] = '{16'h8400, 16'h0200};
    bit seen = 0;
    begin_vec(2);
    feed(q, 0, 0);
    valid_in = 1'b0;
    @(negedge clk);
    if (sum_out !== 16'h0200 || sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL neg_sum got=%h/%b exp=0200/0", sum_out, sum_ovf);
    end
    n_checks++;
    @(negedge clk);
    start = 1'b1; len = 10'd0;
    for (int c = 0; c < 6; c++) begin
      valid_in = 1'b1; in_x = 16'h0100;
      @(negedge clk);
      start = 1'b0;
      if (busy !== 1'b0 || sum_valid !== 1'b0) seen = 1;
    end
    valid_in = 1'b0;
    if (seen) begin n_fail++; $display("FAIL zero_len busy/valid asserted got=1 exp=0"); end
    n_checks++;
    if (sum_out !== 16'h0200) begin n_fail++; $display("FAIL zero_len_hold got=%h exp=0200", sum_out); end
    n_checks++;
  endtask

  task automatic test_reset_mid();
    logic [15:0] q[$] = '{16'h0300, 16'h0300};
    logic [15:0] q1[$] = '{16'h0100};
    bit seen = 0;
    begin_vec(5);
    feed(q, 0, 0);
    #2 rst = 1'b0;
    #1;
    if (busy !== 1'b0 || sum_valid !== 1'b0 || sum_out !== 16'h0 || sum_ovf !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid got busy=%b valid=%b sum=%h ovf=%b exp=0/0/0000/0",
                         busy, sum_valid, sum_out, sum_ovf);
    end
    n_checks++;
    @(negedge clk);
    rst = 1'b1;
    for (int c = 0; c < 6; c++) begin
      valid_in = 1'b1; in_x = 16'h0300;
      @(negedge clk);
      if (sum_valid !== 1'b0 || busy !== 1'b0) seen = 1;
    end
    valid_in = 1'b0;
    if (seen) begin n_fail++; $display("FAIL rst_partial_emit got=1 exp=0"); end
    n_checks++;
    begin_vec(1);
    feed(q1, 0, 0);
    valid_in = 1'b0;
    @(negedge clk);
    if (sum_valid !== 1'b1 || sum_out !== 16'h0100) begin
      n_fail++; $display("FAIL rst_after_sum valid=%b got=%h exp=1/0100", sum_valid, sum_out);
    end
    n_checks++;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [15:0] qa[$];
    logic [15:0] qb[$];
    logic [15:0] es;
    logic        eo;
    int          nb;
    for (int i = 0; i < 3; i++) qa.push_back(16'($urandom_range(0, 16'h0FFF)));
    nb = $urandom_range(2, 5);
    for (int i = 0; i < nb; i++) qb.push_back(16'($urandom_range(0, 16'h0FFF)));
    begin_vec(3);
    feed(qa, 0, 0);
    valid_in = 1'b1; in_x = 16'h1234;
    @(negedge clk);
    ref_sum(qa, es, eo);
    if (sum_valid !== 1'b1 || sum_out !== es) begin
      n_fail++; $display("FAIL b2b_first valid=%b got=%h exp=1/%h", sum_valid, sum_out, es);
    end
    n_checks++;
    start = 1'b1; len = 10'(nb); valid_in = 1'b1; in_x = 16'h2222;
    @(negedge clk);
    start = 1'b0;
    if (busy !== 1'b1 || sum_valid !== 1'b0) begin
      n_fail++; $display("FAIL b2b_restart busy=%b valid=%b exp=1/0", busy, sum_valid);
    end
    n_checks++;
    feed(qb, 20, 20);
    valid_in = 1'b0;
    @(negedge clk);
    ref_sum(qb, es, eo);
    if (sum_valid !== 1'b1 || sum_out !== es || sum_ovf !== eo) begin
      n_fail++; $display("FAIL b2b_second valid=%b got=%h/%b exp=1/%h/%b", sum_valid, sum_out, sum_ovf, es, eo);
    end
    n_checks++;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int v = 0; v < 12; v++) begin
      logic [15:0] q[$];
      logic [15:0] es;
      logic        eo;
      int          n = $urandom_range(1, 24);
      bit          big = ($urandom % 3) == 0;
      for (int i = 0; i < n; i++) begin
        if (($urandom % 100) < 25) q.push_back(16'($urandom_range(16'h8000, 16'hFFFF)));
        else if (big) q.push_back(16'($urandom_range(16'h4000, 16'h7FFF)));
        else q.push_back(16'($urandom_range(0, 16'h07FF)));
      end
      ref_sum(q, es, eo);
      en = 1'b1; valid_in = 1'b1; in_x = 16'h0700;
      @(negedge clk);
      begin_vec(n);
      feed(q, 25, 15);
      valid_in = 1'b0;
      @(negedge clk);
      if (sum_valid !== 1'b1 || sum_out !== es || sum_ovf !== eo) begin
        n_fail++; $display("FAIL rand_vec%0d len=%0d valid=%b got=%h/%b exp=1/%h/%b",
                           v, n, sum_valid, sum_out, sum_ovf, es, eo);
      end
      n_checks++;
      @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b0; en = 1'b1; start = 1'b0; len = '0; valid_in = 1'b0; in_x = '0;
    repeat (2) @(negedge clk);
    test_reset();
    rst = 1'b1;
    @(negedge clk);
    test_dense();
    test_gaps_stalls();
    test_saturate();
    test_negative_and_zero_len();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
